// File: rtl/snake_pkg.sv
// Shared encodings for the snake sequencer: directions, stages, step status and FSM states.
// Also holds the direction reversal helper used by the key queue.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    STAGE_PLAY = 2'd0,
    STAGE_LOSE = 2'd1,
    STAGE_WIN  = 2'd2
  } stage_e;

  typedef enum logic [1:0] {
    ST_MOVED = 2'd0,
    ST_ATE   = 2'd1,
    ST_HIT   = 2'd2,
    ST_FULL  = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    FSM_WAIT  = 2'd0,
    FSM_ISSUE = 2'd1,
    FSM_LOSE  = 2'd2,
    FSM_WIN   = 2'd3
  } fsm_e;

  localparam int unsigned PERIOD_W = 23;
  localparam int unsigned ROLL_W   = 7;

  // Opposite directions share the axis bit and differ in the sense bit.
  function automatic logic is_reverse(input dir_e a, input dir_e b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Arrow-key front end: per-key synchroniser and rising-edge detect, priority pick,
// reversal/duplicate filter and a small shift FIFO of pending directions.
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic push_en,
  input  logic pop,
  input  dir_e cur_dir,
  output dir_e head,
  output logic empty
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [3:0]       sync1_q, sync2_q, prev_q;
  logic [3:0]       rise_s;
  logic             cand_valid_s;
  dir_e             cand_s;
  dir_e             ref_s;
  dir_e             entries_q [QDEPTH];
  dir_e             entries_d [QDEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // Key synchroniser and edge-detect history, bit index equals direction code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      prev_q  <= 4'b0000;
    end else begin
      sync1_q <= {btn_right, btn_left, btn_down, btn_up};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Priority pick among this cycle's edges; the losers are simply discarded.
  always_comb begin
    rise_s       = sync2_q & ~prev_q;
    cand_valid_s = 1'b1;
    cand_s       = DIR_UP;
    if (rise_s[0]) begin
      cand_s = DIR_UP;
    end else if (rise_s[1]) begin
      cand_s = DIR_DOWN;
    end else if (rise_s[2]) begin
      cand_s = DIR_LEFT;
    end else if (rise_s[3]) begin
      cand_s = DIR_RIGHT;
    end else begin
      cand_valid_s = 1'b0;
    end
  end

  // Pop first, then filter the candidate against whatever direction will precede it.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    ref_s     = cur_dir;
    if (pop && (count_q != '0)) begin
      ref_s = entries_q[0];
      for (int i = 0; i < int'(QDEPTH) - 1; i++) begin
        entries_d[i] = entries_q[i + 1];
      end
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
    for (int i = 0; i < int'(QDEPTH); i++) begin
      ref_s = (count_d == CNT_W'(i + 1)) ? entries_d[i] : ref_s;
    end
    if (push_en && cand_valid_s && (count_d != CNT_W'(QDEPTH)) &&
        (cand_s != ref_s) && !is_reverse(cand_s, ref_s)) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        entries_d[i] = (count_d == CNT_W'(i)) ? cand_s : entries_d[i];
      end
      count_d = count_d + CNT_W'(1);
    end else begin
      count_d = count_d;
    end
  end

  // Queue storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        entries_q[i] <= DIR_DOWN;
      end
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign head  = entries_q[0];
  assign empty = (count_q == '0);

endmodule

// File: rtl/snake_game_sequencer.sv
// Game sequencer: tick timing with speed-ups, step request handshake to the datapath,
// play/lose/win stage FSM and result-scroll roll counter, all in the clk domain.
module snake_game_sequencer
  import snake_pkg::*;
#(
  parameter int unsigned TICK_CYCLES  = 5_000_000,
  parameter int unsigned MIN_TICK     = 1_000_000,
  parameter int unsigned SPEEDUP_STEP = 100_000,
  parameter int unsigned ROLL_MAX     = 80,
  parameter int unsigned QDEPTH       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        force_win,
  output logic        step_req,
  output logic [1:0]  step_dir,
  input  logic        step_ack,
  input  logic [1:0]  step_status,
  output logic [1:0]  stage,
  output logic [6:0]  roll,
  output logic        tick
);

  localparam int unsigned PW1 = PERIOD_W + 1;
  localparam logic [PERIOD_W-1:0] TICK_P  = PERIOD_W'(TICK_CYCLES);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_TICK);
  localparam logic [PERIOD_W-1:0] SPEED_P = PERIOD_W'(SPEEDUP_STEP);
  localparam logic [PW1-1:0]      FLOOR_P = PW1'(MIN_TICK) + PW1'(SPEEDUP_STEP);
  localparam logic [ROLL_W-1:0]   RMAX_P  = ROLL_W'(ROLL_MAX);

  fsm_e                state_q, state_d;
  stage_e              stage_q, stage_d;
  dir_e                cur_dir_q, cur_dir_d;
  dir_e                step_dir_q, step_dir_d;
  logic                step_req_q, step_req_d;
  logic                tick_q, tick_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [ROLL_W-1:0]   roll_q, roll_d;
  logic                fw_sync1_q, fw_sync2_q, fw_prev_q;

  logic fw_edge_s, freeze_s, tick_s, ack_s, pop_s, push_en_s, empty_s;
  dir_e head_s;

  assign fw_edge_s = fw_sync2_q & ~fw_prev_q;
  assign freeze_s  = (state_q == FSM_ISSUE);
  assign tick_s    = !freeze_s && (cnt_q == period_q - PERIOD_W'(1));
  assign ack_s     = step_ack && (state_q == FSM_ISSUE);
  assign pop_s     = (state_q == FSM_WAIT) && tick_s && !fw_edge_s;
  assign push_en_s = ((state_q == FSM_WAIT) || (state_q == FSM_ISSUE)) && !fw_edge_s;

  snake_dir_queue #(.QDEPTH(QDEPTH)) u_dir_queue (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .push_en   (push_en_s),
    .pop       (pop_s),
    .cur_dir   (cur_dir_q),
    .head      (head_s),
    .empty     (empty_s)
  );

  // Synchronise and edge-detect the force_win test key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fw_sync1_q <= 1'b0;
      fw_sync2_q <= 1'b0;
      fw_prev_q  <= 1'b0;
    end else begin
      fw_sync1_q <= force_win;
      fw_sync2_q <= fw_sync1_q;
      fw_prev_q  <= fw_sync2_q;
    end
  end

  // Next-state: tick counter, step handshake, speed-up, roll and stage.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    roll_d     = roll_q;
    cur_dir_d  = cur_dir_q;
    step_req_d = step_req_q;
    step_dir_d = step_dir_q;
    tick_d     = tick_s;
    if (freeze_s) begin
      cnt_d = cnt_q;
    end else if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end

    case (state_q)
      FSM_WAIT: begin
        if (tick_s) begin
          cur_dir_d  = empty_s ? cur_dir_q : head_s;
          step_dir_d = empty_s ? cur_dir_q : head_s;
          step_req_d = 1'b1;
          state_d    = FSM_ISSUE;
        end else begin
          state_d = FSM_WAIT;
        end
      end
      FSM_ISSUE: begin
        if (ack_s) begin
          step_req_d = 1'b0;
          cnt_d      = '0;
          case (status_e'(step_status))
            ST_MOVED: state_d = FSM_WAIT;
            ST_ATE: begin
              state_d = FSM_WAIT;
              // Guard the subtraction so the clamp never sees an underflowed period.
              if ({1'b0, period_q} >= FLOOR_P) begin
                period_d = period_q - SPEED_P;
              end else begin
                period_d = MIN_P;
              end
            end
            ST_HIT:  state_d = FSM_LOSE;
            ST_FULL: state_d = FSM_WIN;
            default: state_d = FSM_WAIT;
          endcase
        end else begin
          state_d = FSM_ISSUE;
        end
      end
      FSM_LOSE, FSM_WIN: begin
        if (tick_s) begin
          roll_d = (roll_q == RMAX_P) ? '0 : roll_q + ROLL_W'(1);
        end else begin
          roll_d = roll_q;
        end
      end
      default: state_d = FSM_WAIT;
    endcase

    if (fw_edge_s) begin
      state_d    = FSM_WIN;
      roll_d     = '0;
      step_req_d = 1'b0;
      cnt_d      = '0;
      cur_dir_d  = cur_dir_q;
      step_dir_d = step_dir_q;
    end else begin
      state_d = state_d;
    end

    case (state_d)
      FSM_LOSE: stage_d = STAGE_LOSE;
      FSM_WIN:  stage_d = STAGE_WIN;
      default:  stage_d = STAGE_PLAY;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FSM_WAIT;
      stage_q    <= STAGE_PLAY;
      cur_dir_q  <= DIR_DOWN;
      step_dir_q <= DIR_DOWN;
      step_req_q <= 1'b0;
      tick_q     <= 1'b0;
      cnt_q      <= '0;
      period_q   <= TICK_P;
      roll_q     <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      cur_dir_q  <= cur_dir_d;
      step_dir_q <= step_dir_d;
      step_req_q <= step_req_d;
      tick_q     <= tick_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      roll_q     <= roll_d;
    end
  end

  assign step_req = step_req_q;
  assign step_dir = step_dir_q;
  assign stage    = stage_q;
  assign roll     = roll_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed and randomized checks of snake_game_sequencer against a cycle-level
// behavioural model of the game rules (small tick periods for fast runs).
module tb_snake_game_sequencer;

  logic       clk;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right, force_win;
  logic       step_ack;
  logic [1:0] step_status;
  logic       step_req;
  logic [1:0] step_dir;
  logic [1:0] stage;
  logic [6:0] roll;
  logic       tick;

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state (stage 0 play, 1 lose, 2 win).
  int   m_stage, m_req, m_dir, m_cur, m_roll, m_tick, m_cnt, m_period;
  int   q[$];
  logic [3:0] kh1, kh2, kh3;
  logic fh1, fh2, fh3;

  snake_game_sequencer #(
    .TICK_CYCLES(10), .MIN_TICK(4), .SPEEDUP_STEP(3), .ROLL_MAX(80), .QDEPTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .force_win(force_win),
    .step_req(step_req), .step_dir(step_dir), .step_ack(step_ack), .step_status(step_status),
    .stage(stage), .roll(roll), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_rev(input int a, input int b);
    return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_stage = 0; m_req = 0; m_dir = 1; m_cur = 1; m_roll = 0; m_tick = 0;
    m_cnt = 0; m_period = 10;
    q.delete();
    kh1 = 4'b0000; kh2 = 4'b0000; kh3 = 4'b0000;
    fh1 = 1'b0; fh2 = 1'b0; fh3 = 1'b0;
  endtask

  // One clock edge of the game rules; keys take effect two edges after being sampled.
  task automatic model_edge();
    logic [3:0] kedge;
    logic fedge;
    bit   tick_now, was_play;
    int   cand, refd;
    kedge = kh2 & ~kh3;
    fedge = fh2 & ~fh3;
    kh3 = kh2; kh2 = kh1; kh1 = {btn_right, btn_left, btn_down, btn_up};
    fh3 = fh2; fh2 = fh1; fh1 = force_win;
    was_play = (m_stage == 0);
    tick_now = !(m_stage == 0 && m_req == 1) && (m_cnt == m_period - 1);
    if (fedge) begin
      m_stage = 2; m_roll = 0; m_req = 0; m_cnt = 0;
    end else if (m_stage == 0) begin
      if (m_req == 1) begin
        if (step_ack) begin
          m_req = 0; m_cnt = 0;
          case (step_status)
            2'd1: m_period = (m_period - 3 < 4) ? 4 : m_period - 3;
            2'd2: m_stage = 1;
            2'd3: m_stage = 2;
            default: ;
          endcase
        end
      end else if (tick_now) begin
        m_cnt = 0;
        if (q.size() > 0) m_cur = q.pop_front();
        m_req = 1; m_dir = m_cur;
      end else begin
        m_cnt++;
      end
    end else if (tick_now) begin
      m_cnt = 0;
      m_roll = (m_roll == 80) ? 0 : m_roll + 1;
    end else begin
      m_cnt++;
    end
    if (!fedge && was_play && kedge != 4'b0000) begin
      cand = kedge[0] ? 0 : kedge[1] ? 1 : kedge[2] ? 2 : 3;
      refd = (q.size() > 0) ? q[$] : m_cur;
      if (q.size() < 2 && cand != refd && !is_rev(cand, refd)) q.push_back(cand);
    end
    m_tick = tick_now;
  endtask

  task automatic check_all();
    chk("step_req", step_req, m_req);
    chk("step_dir", step_dir, m_dir);
    chk("stage", stage, m_stage);
    chk("roll", roll, m_roll);
    chk("tick", tick, m_tick);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    check_all();
    @(negedge clk);
    step_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic ack(input logic [1:0] st);
    step_ack = 1'b1;
    step_status = st;
    cyc();
  endtask

  task automatic press(input int k);
    btn_up = (k == 0); btn_down = (k == 1); btn_left = (k == 2); btn_right = (k == 3);
    force_win = (k == 4);
    cyc();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; force_win = 1'b0;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (step_req !== 1'b1 && n < limit) begin
      cyc();
      n++;
    end
    n_total++;
    assert (step_req === 1'b1) n_pass++;
    else $error("FAIL wait_req: observed step_req=%b after %0d cycles, expected 1", step_req, n);
  endtask

  initial begin
    int n, r;
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    force_win = 1'b0; step_ack = 1'b0; step_status = 2'd0;
    #2;
    do_reset();
    chk("rst_step_req", step_req, 0);
    chk("rst_step_dir", step_dir, 1);
    chk("rst_stage", stage, 0);
    chk("rst_roll", roll, 0);

    // First step after reset, then spacing after a moved ack.
    wait_req(40, n); chk("first_req_cycle", n, 10); chk("first_dir", step_dir, 1);
    ack(2'd0);
    chk("req_drop_after_ack", step_req, 0);
    wait_req(40, n); chk("moved_period", n, 10);

    // Two queued turns; a third key while full is dropped.
    ack(2'd0);
    press(2); cyc(); press(0); cyc(); press(3); cyc();
    wait_req(40, n); chk("queued_left", step_dir, 2);
    ack(2'd0); wait_req(40, n); chk("queued_up", step_dir, 0);
    ack(2'd0); wait_req(40, n); chk("right_dropped", step_dir, 0);

    // Speed-ups clamp at the minimum period.
    ack(2'd1); wait_req(40, n); chk("ate_period1", n, 7);
    ack(2'd1); wait_req(40, n); chk("ate_period2", n, 4);
    ack(2'd1); wait_req(40, n); chk("ate_period3", n, 4);

    // Reversal rejection and same-cycle priority.
    do_reset();
    press(0);
    wait_req(40, n); chk("reverse_rejected", step_dir, 1);
    ack(2'd0);
    btn_left = 1'b1; btn_right = 1'b1; cyc(); btn_left = 1'b0; btn_right = 1'b0;
    wait_req(40, n); chk("left_over_right", step_dir, 2);
    ack(2'd0); wait_req(40, n); chk("right_not_queued", step_dir, 2);

    // Lose stage and roll scroll with wrap.
    do_reset();
    wait_req(40, n);
    ack(2'd2);
    chk("lose_stage", stage, 1);
    chk("lose_req", step_req, 0);
    for (int i = 0; i < 10; i++) cyc();
    chk("roll_first", roll, 1);
    press(0); press(2);
    for (int i = 12; i < 800; i++) cyc();
    chk("roll_max", roll, 80);
    for (int i = 0; i < 10; i++) cyc();
    chk("roll_wrap", roll, 0);
    chk("lose_no_req", step_req, 0);

    // force_win with a step pending, then a late ack.
    do_reset();
    wait_req(40, n);
    press(4); cyc(); cyc();
    chk("fw_stage", stage, 2);
    chk("fw_req", step_req, 0);
    chk("fw_roll", roll, 0);
    ack(2'd2);
    chk("late_ack_stage", stage, 2);
    chk("late_ack_req", step_req, 0);

    // Reset in the middle of a step.
    do_reset();
    wait_req(40, n);
    reset = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_req", step_req, 0);
    chk("mid_rst_dir", step_dir, 1);
    chk("mid_rst_stage", stage, 0);
    cyc();
    reset = 1'b1;

    // Randomized play against the model.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        btn_up    = ($urandom_range(0, 11) == 0);
        btn_down  = ($urandom_range(0, 11) == 0);
        btn_left  = ($urandom_range(0, 11) == 0);
        btn_right = ($urandom_range(0, 11) == 0);
        force_win = ($urandom_range(0, 299) == 0);
        if (m_req == 1 && $urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 19);
          step_ack = 1'b1;
          step_status = (r == 0) ? 2'd2 : (r == 1) ? 2'd3 : (r < 8) ? 2'd1 : 2'd0;
        end else if (m_req == 0 && $urandom_range(0, 9) == 0) begin
          step_ack = 1'b1;
          step_status = 2'($urandom_range(0, 3));
        end
        cyc();
      end
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; force_win = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
